// File: rtl/myproject_acc_pkg.sv
// Shared types and constants for the dense-layer accumulator: FSM states,
// accumulator width and rounding/saturation helper constants.
package myproject_acc_pkg;

   typedef enum logic [1:0] {
      ST_FIRST = 2'd0,
      ST_ACCUM = 2'd1,
      ST_HOLD  = 2'd2
   } acc_state_e;

   function automatic int acc_width(input int prod_w, input int n_in);
      return prod_w + $clog2(n_in) + 1;
   endfunction

   // Half an output LSB, added before the shift to get round-half-up.
   function automatic longint round_half(input int shift);
      return longint'(1) <<< (shift - 1);
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/myproject_round_sat.sv
// Combinational round-half-up, arithmetic right shift, optional ReLU
// (MYPROJECT_ACC_RELU_EN) and saturation of an accumulator sum.
module myproject_round_sat
   import myproject_acc_pkg::*;
#(
   parameter int IN_W  = 24,
   parameter int OUT_W = 16,
   parameter int SHIFT = 6
) (
   input  logic [IN_W-1:0]  sum_i,
   output logic [OUT_W-1:0] data_o,
   output logic             sat_o
);

   // One guard bit above the accumulator keeps the rounding add from wrapping.
   localparam int XW = IN_W + 1;
   localparam logic signed [XW-1:0] RND   = XW'(round_half(SHIFT));
   localparam logic signed [XW-1:0] MAX_V = XW'(sat_max(OUT_W));
   localparam logic signed [XW-1:0] MIN_V = XW'(sat_min(OUT_W));

   logic signed [XW-1:0] sum_x;
   logic signed [XW-1:0] r;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch can never be inferred.
   always_comb begin
      sum_x  = {sum_i[IN_W-1], sum_i};
      r      = (sum_x + RND) >>> SHIFT;
`ifdef MYPROJECT_ACC_RELU_EN
      if (r[XW-1]) begin
         r = '0;
      end
`endif
      data_o = r[OUT_W-1:0];
      sat_o  = 1'b0;
      if (r > MAX_V) begin
         data_o = MAX_V[OUT_W-1:0];
         sat_o  = 1'b1;
      end else if (r < MIN_V) begin
         data_o = MIN_V[OUT_W-1:0];
         sat_o  = 1'b1;
      end
   end

endmodule

// File: rtl/myproject_dense_acc.sv
// Dense-layer accumulator: bias-seeded sum of a product stream, rescaled and
// saturated on the terminal beat. Build option: MYPROJECT_ACC_RELU_EN.
module myproject_dense_acc
   import myproject_acc_pkg::*;
#(
   parameter int PROD_WIDTH = 19,
   parameter int N_IN       = 16,
   parameter int BIAS_WIDTH = 12,
   parameter int FRAC_SHIFT = 6,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PROD_WIDTH-1:0] in_product,
   input  logic [BIAS_WIDTH-1:0] in_bias,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OUT_WIDTH-1:0]  out_data,
   output logic                  out_sat,
   output logic                  out_err
);

   localparam int ACC_WIDTH = acc_width(PROD_WIDTH, N_IN);
   localparam int CNT_W     = $clog2(N_IN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

   acc_state_e             state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic                   sat_q, sat_d;
   logic                   err_q, err_d;

   logic                   beat;
   logic                   full_beat;
   logic [ACC_WIDTH-1:0]   prod_x;
   logic [ACC_WIDTH-1:0]   bias_x;
   logic [OUT_WIDTH-1:0]   rs_data;
   logic                   rs_sat;

   assign prod_x    = ACC_WIDTH'($signed(in_product));
   assign bias_x    = ACC_WIDTH'($signed(in_bias));
   assign in_ready  = ap_rst_n && (state_q != ST_HOLD);
   assign beat      = in_valid && in_ready;
   // cnt_q is zero in FIRST, so this also covers a group size of one.
   assign full_beat = (cnt_q == CNT_LAST);

   assign out_valid = (state_q == ST_HOLD);
   assign out_data  = data_q;
   assign out_sat   = sat_q;
   assign out_err   = err_q;

   // Fed from the next-state sum so the result registers on the terminal beat.
   myproject_round_sat #(
      .IN_W  (ACC_WIDTH),
      .OUT_W (OUT_WIDTH),
      .SHIFT (FRAC_SHIFT)
   ) u_round_sat (
      .sum_i  (acc_d),
      .data_o (rs_data),
      .sat_o  (rs_sat)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      sat_d   = sat_q;
      err_d   = err_q;
      case (state_q)
         ST_FIRST, ST_ACCUM: begin
            if (beat) begin
               if (state_q == ST_FIRST) begin
                  acc_d = bias_x + prod_x;
                  cnt_d = CNT_W'(1);
               end else begin
                  acc_d = acc_q + prod_x;
                  cnt_d = cnt_q + CNT_W'(1);
               end
               state_d = ST_ACCUM;
               if (in_last || full_beat) begin
                  state_d = ST_HOLD;
                  data_d  = rs_data;
                  sat_d   = rs_sat;
                  err_d   = !in_last;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               state_d = ST_FIRST;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_FIRST;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= ST_FIRST;
         acc_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         sat_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         sat_q   <= sat_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_myproject_dense_acc.sv
// Directed self-checking bench for myproject_dense_acc (default parameters).
module tb_myproject_dense_acc;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [18:0] in_product = '0;
   logic [11:0] in_bias = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic        out_sat;
   logic        out_err;

   int total = 0;
   int bad   = 0;

   myproject_dense_acc dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .in_bias    (in_bias),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_sat    (out_sat),
      .out_err    (out_err)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic send_beat(input int p, input int b, input logic l);
      int n = 0;
      in_valid = 1'b1; in_product = 19'(p); in_bias = 12'(b); in_last = l;
      while (!in_ready && n < 50) begin
         @(posedge ap_clk); #1; n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL beat_wait: in_ready=%b required 1", in_ready);
      end
      @(posedge ap_clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      total++;
      if ({out_valid, in_ready, out_data, out_sat, out_err} !== 20'h0) begin
         bad++;
         $display("FAIL reset_state: valid=%b ready=%b data=%0d sat=%b err=%b required all 0",
                  out_valid, in_ready, out_data, out_sat, out_err);
      end
      @(posedge ap_clk); #2;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_basic();
      send_beat(64, 32, 1'b0);
      send_beat(64, 32, 1'b0);
      total++;
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_early_valid: out_valid=%b required 0", out_valid);
      end
      send_beat(64, 32, 1'b1);
      total++;
      if ({out_valid, out_data, out_sat, out_err} !== {1'b1, 16'sd4, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL basic_result: valid=%b data=%0d sat=%b err=%b required 1/4/0/0",
                  out_valid, $signed(out_data), out_sat, out_err);
      end
      ack();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL basic_ack: valid=%b ready=%b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_single_negative();
      logic [15:0] exp_d;
`ifdef MYPROJECT_ACC_RELU_EN
      exp_d = 16'sd0;
`else
      exp_d = -16'sd1;
`endif
      send_beat(-64, -32, 1'b1);
      total++;
      if ({out_valid, out_data, out_sat, out_err} !== {1'b1, exp_d, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL single_neg: valid=%b data=%0d sat=%b err=%b required 1/%0d/0/0",
                  out_valid, $signed(out_data), out_sat, out_err, $signed(exp_d));
      end
      ack();
   endtask

   task automatic test_sat_pos();
      for (int i = 0; i < 16; i++) send_beat(262143, 32, (i == 15));
      total++;
      if ({out_valid, out_data, out_sat, out_err} !== {1'b1, 16'h7FFF, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL sat_pos: valid=%b data=%0d sat=%b err=%b required 1/32767/1/0",
                  out_valid, $signed(out_data), out_sat, out_err);
      end
      ack();
   endtask

   task automatic test_sat_neg();
      logic [15:0] exp_d;
      logic        exp_s;
`ifdef MYPROJECT_ACC_RELU_EN
      exp_d = 16'h0000; exp_s = 1'b0;
`else
      exp_d = 16'h8000; exp_s = 1'b1;
`endif
      for (int i = 0; i < 16; i++) send_beat(-262144, -2048, (i == 15));
      total++;
      if ({out_valid, out_data, out_sat, out_err} !== {1'b1, exp_d, exp_s, 1'b0}) begin
         bad++;
         $display("FAIL sat_neg: valid=%b data=%0d sat=%b err=%b required 1/%0d/%b/0",
                  out_valid, $signed(out_data), out_sat, out_err, $signed(exp_d), exp_s);
      end
      ack();
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) send_beat(1, 0, 1'b0);
      total++;
      if ({out_valid, out_data, out_sat, out_err} !== {1'b1, 16'sd0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL overrun_result: valid=%b data=%0d sat=%b err=%b required 1/0/0/1",
                  out_valid, $signed(out_data), out_sat, out_err);
      end
      ack();
      // New group must re-sample the bias: (100 + 640 + 32) >>> 6 = 12.
      send_beat(640, 100, 1'b1);
      total++;
      if ({out_valid, out_data, out_err} !== {1'b1, 16'sd12, 1'b0}) begin
         bad++;
         $display("FAIL overrun_next_group: valid=%b data=%0d err=%b required 1/12/0",
                  out_valid, $signed(out_data), out_err);
      end
      ack();
   endtask

   task automatic test_back_to_back();
      send_beat(320, 0, 1'b1);
      in_valid = 1'b1; in_product = 19'd64; in_bias = 12'd0; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         total++;
         if (out_valid !== 1'b1 || out_data !== 16'sd5 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_cycle%0d: valid=%b data=%0d ready=%b required 1/5/0",
                     c, out_valid, $signed(out_data), in_ready);
         end
         @(posedge ap_clk); #1;
      end
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL hold_release: valid=%b ready=%b required 0/1", out_valid, in_ready);
      end
      @(posedge ap_clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'sd1) begin
         bad++;
         $display("FAIL held_beat_result: valid=%b data=%0d required 1/1",
                  out_valid, $signed(out_data));
      end
      ack();
   endtask

   task automatic test_midgroup_reset();
      send_beat(1000, 0, 1'b0);
      send_beat(1000, 0, 1'b0);
      #2;
      ap_rst_n = 1'b0;
      #1;
      total++;
      if ({out_valid, in_ready, out_data, out_sat, out_err} !== 20'h0) begin
         bad++;
         $display("FAIL midgroup_reset: valid=%b ready=%b data=%0d sat=%b err=%b required all 0",
                  out_valid, in_ready, out_data, out_sat, out_err);
      end
      @(posedge ap_clk); #2;
      ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      send_beat(128, 0, 1'b1);
      total++;
      if ({out_valid, out_data, out_sat, out_err} !== {1'b1, 16'sd2, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL post_reset_group: valid=%b data=%0d sat=%b err=%b required 1/2/0/0",
                  out_valid, $signed(out_data), out_sat, out_err);
      end
      ack();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_single_negative();
      test_sat_pos();
      test_sat_neg();
      test_overrun();
      test_back_to_back();
      test_midgroup_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
